// File: rtl/nebula_pkg.sv
// Purpose: shared constants, ALU op encoding and FSM state type for the Nebula core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nebula_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Major opcodes
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 codes shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 codes: ALT selects SUB / SRA
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic {
        IDLE,
        EXEC
    } state_e;

    // Base (funct7 = 0) mapping of funct3 to an ALU operation.
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
        case (f3)
            F3_ADD:  return ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/nebula_alu.sv
// Purpose: combinational RV32I integer ALU (a, b, op -> result).
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a/b operands, op selects the function, result is the wrapped XLEN-bit output.
module nebula_alu
    import nebula_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << shamt;
            ALU_SLT:    result[0] = ($signed(a) < $signed(b));
            ALU_SLTU:   result[0] = (a < b);
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/nebula_soc_top.sv
// Purpose: Nebula core top; runs 128-bit blocks of four RV32I ops against a 32x32 regfile.
// Latency: first retire 1 cycle after the accept edge; one slot per cycle, 4 cycles per block.
// Backpressure: none; offers arriving while busy are dropped, not queued.
// Ports: block_*_in offer a block (level valid), busy/retire_*/block_done/block_id_out report progress.
module nebula_soc_top
    import nebula_pkg::*;
#(
    parameter int ID_W = 7,
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [127:0]    block_data_in,
    input  logic [ID_W-1:0] block_id_in,
    input  logic            block_valid_in,
    output logic            busy,
    output logic            retire_valid,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data,
    output logic            retire_illegal,
    output logic            block_done,
    output logic [ID_W-1:0] block_id_out
);

    state_e          state, state_nxt;
    logic [1:0]      slot;
    logic [127:0]    blk_dat;      // doubles as the "last accepted" data for duplicate filtering
    logic            prev_valid;
    logic [XLEN-1:0] rf [32];

    logic            exec;
    logic            accept;
    logic [31:0]     instr;
    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_u, opb, alu_res, wr_data;
    logic            illegal, wr_en;
    alu_op_e         alu_op;

    assign exec = (state == EXEC);

    // A held-high valid only re-triggers when the offered {id,data} changes.
    assign accept = (state == IDLE) && block_valid_in &&
                    (!prev_valid || ({block_id_in, block_data_in} != {block_id_out, blk_dat}));

    // Slot 0 lives in the top word and executes first.
    always_comb begin
        case (slot)
            2'd1:    instr = blk_dat[95:64];
            2'd2:    instr = blk_dat[63:32];
            2'd3:    instr = blk_dat[31:0];
            default: instr = blk_dat[127:96];
        endcase
    end

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign f3      = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign f7      = instr[31:25];
    assign imm_i   = XLEN'($signed(instr[31:20]));
    assign imm_u   = XLEN'($signed({instr[31:12], 12'h000}));
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

    always_comb begin
        alu_op  = ALU_ADD;
        opb     = rs2_val;
        illegal = 1'b1;
        case (opcode)
            OPC_OP_IMM: begin
                illegal = 1'b0;
                opb     = imm_i;
                alu_op  = f3_to_alu(f3);
                // Shift-immediates carry funct7 in imm[11:5]; only the defined encodings are legal.
                if (f3 == F3_SLL && f7 != F7_BASE) begin
                    illegal = 1'b1;
                end
                if (f3 == F3_SR) begin
                    if (f7 == F7_ALT) begin
                        alu_op = ALU_SRA;
                    end else if (f7 != F7_BASE) begin
                        illegal = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                illegal = 1'b0;
                alu_op  = f3_to_alu(f3);
                if (f7 == F7_ALT) begin
                    if (f3 == F3_ADD) begin
                        alu_op = ALU_SUB;
                    end else if (f3 == F3_SR) begin
                        alu_op = ALU_SRA;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (f7 != F7_BASE) begin
                    illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                illegal = 1'b0;
                opb     = imm_u;
                alu_op  = ALU_PASS_B;
            end
            default: ;
        endcase
    end

    nebula_alu #(.XLEN(XLEN)) u_alu (
        .a      (rs1_val),
        .b      (opb),
        .op     (alu_op),
        .result (alu_res)
    );

    assign wr_en   = exec && !illegal && (rd != 5'd0);
    assign wr_data = wr_en ? alu_res : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (slot == 2'd3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            slot           <= 2'd0;
            blk_dat        <= '0;
            block_id_out   <= '0;
            prev_valid     <= 1'b0;
            busy           <= 1'b0;
            retire_valid   <= 1'b0;
            retire_rd      <= 5'd0;
            retire_data    <= '0;
            retire_illegal <= 1'b0;
            block_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_valid <= block_valid_in;
            busy       <= (state_nxt == EXEC);
            if (accept) begin
                blk_dat      <= block_data_in;
                block_id_out <= block_id_in;
                slot         <= 2'd0;
            end else if (exec) begin
                slot <= slot + 2'd1;
            end
            retire_valid   <= exec;
            retire_rd      <= exec ? rd : 5'd0;
            retire_data    <= wr_data;
            retire_illegal <= exec && illegal;
            block_done     <= exec && (slot == 2'd3);
        end
    end

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[rd] <= wr_data;
        end
    end

endmodule

// File: tb/tb_nebula_soc_top.sv
module tb_nebula_soc_top;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] block_data_in;
    logic [6:0]   block_id_in;
    logic         block_valid_in;
    logic         busy;
    logic         retire_valid;
    logic [4:0]   retire_rd;
    logic [31:0]  retire_data;
    logic         retire_illegal;
    logic         block_done;
    logic [6:0]   block_id_out;

    always #5 clk = ~clk;

    nebula_soc_top dut (
        .clk            (clk),
        .rst            (rst),
        .block_data_in  (block_data_in),
        .block_id_in    (block_id_in),
        .block_valid_in (block_valid_in),
        .busy           (busy),
        .retire_valid   (retire_valid),
        .retire_rd      (retire_rd),
        .retire_data    (retire_data),
        .retire_illegal (retire_illegal),
        .block_done     (block_done),
        .block_id_out   (block_id_out)
    );

    localparam logic [127:0] B1 = 128'h00500513_00520293_00600593_00628313;
    localparam logic [127:0] B2 = 128'h00418213_00520293_00628313_00730393;
    localparam logic [127:0] B_INTRUDER = 128'h7FF00A13_7FF00A13_7FF00A13_7FF00A13;
    localparam logic [127:0] B_READBACK = 128'h000A0AB3_00000013_00000013_00000013;
    localparam logic [127:0] B_SIGNED = 128'hFFF00093_0010B113_00500013_0000007F;
    localparam logic [127:0] B_ALU = 128'h80000437_40445493_40100633_0000A6B3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0]  cap_rd   [16];
    logic [31:0] cap_dat  [16];
    logic        cap_ill  [16];
    logic        cap_done [16];
    logic [6:0]  cap_id   [16];
    int          cap_n;

    task automatic cap_clear();
        cap_n = 0;
        for (int i = 0; i < 16; i++) begin
            cap_rd[i] = 'x; cap_dat[i] = 'x; cap_ill[i] = 1'bx; cap_done[i] = 1'bx; cap_id[i] = 'x;
        end
    endtask

    // Records every retire seen over a bounded number of cycles (sampled on negedge).
    task automatic capture(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (retire_valid === 1'b1) begin
                if (cap_n < 16) begin
                    cap_rd[cap_n]   = retire_rd;
                    cap_dat[cap_n]  = retire_data;
                    cap_ill[cap_n]  = retire_illegal;
                    cap_done[cap_n] = block_done;
                    cap_id[cap_n]   = block_id_out;
                end
                cap_n++;
            end
        end
    endtask

    task automatic offer(input logic [127:0] d, input logic [6:0] id);
        @(negedge clk);
        block_data_in  = d;
        block_id_in    = id;
        block_valid_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; block_valid_in = 1'b0; block_data_in = '0; block_id_in = '0;
        #2 rst = 1'b0;
        #20;
        n_cmp++;
        if ({busy, retire_valid, retire_rd, retire_data, retire_illegal, block_done, block_id_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b rv=%b rd=%0d data=%h ill=%b done=%b id=%h, want all 0",
                     busy, retire_valid, retire_rd, retire_data, retire_illegal, block_done, block_id_out);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [4:0]  erd [4];
        logic [31:0] edat [4];
        erd = '{5'd10, 5'd5, 5'd11, 5'd6};
        edat = '{32'd5, 32'd5, 32'd6, 32'd11};
        cap_clear();
        offer(B1, 7'h01);
        capture(1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_busy: got %b want 1", busy);
        end
        capture(7);
        n_cmp++;
        if (cap_n !== 4) begin
            n_bad++; $display("FAIL basic_count: got %0d retires want 4", cap_n);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cap_rd[k] !== erd[k] || cap_dat[k] !== edat[k] || cap_ill[k] !== 1'b0 || cap_done[k] !== (k == 3)) begin
                n_bad++;
                $display("FAIL basic_slot%0d: got rd=%0d data=%h ill=%b done=%b, want rd=%0d data=%h ill=0 done=%b",
                         k, cap_rd[k], cap_dat[k], cap_ill[k], cap_done[k], erd[k], edat[k], (k == 3));
            end
        end
        n_cmp++;
        if (cap_id[3] !== 7'h01 || busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_id_idle: got id=%h busy=%b want id=01 busy=0", cap_id[3], busy);
        end
    endtask

    task automatic test_hold();
        cap_clear();
        capture(50000);
        n_cmp++;
        if (cap_n !== 0) begin
            n_bad++; $display("FAIL hold_no_rerun: got %0d retires want 0", cap_n);
        end
    endtask

    task automatic test_change();
        logic [4:0]  erd [4];
        logic [31:0] edat [4];
        erd = '{5'd4, 5'd5, 5'd6, 5'd7};
        edat = '{32'd4, 32'd9, 32'd15, 32'd22};
        cap_clear();
        offer(B2, 7'h01);
        capture(8);
        block_valid_in = 1'b0;
        n_cmp++;
        if (cap_n !== 4) begin
            n_bad++; $display("FAIL change_count: got %0d retires want 4", cap_n);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cap_rd[k] !== erd[k] || cap_dat[k] !== edat[k] || cap_done[k] !== (k == 3)) begin
                n_bad++;
                $display("FAIL change_slot%0d: got rd=%0d data=%h done=%b, want rd=%0d data=%h done=%b",
                         k, cap_rd[k], cap_dat[k], cap_done[k], erd[k], edat[k], (k == 3));
            end
        end
    endtask

    task automatic test_busy_offer();
        logic [4:0]  erd [4];
        logic [31:0] edat [4];
        // x4 still holds 4 from the previous block, so slot1 yields 9 and slot3 yields 15.
        erd = '{5'd10, 5'd5, 5'd11, 5'd6};
        edat = '{32'd5, 32'd9, 32'd6, 32'd15};
        cap_clear();
        offer(B1, 7'h03);
        capture(2);
        block_data_in = B_INTRUDER; block_id_in = 7'h04;
        capture(1);
        block_valid_in = 1'b0;
        capture(8);
        n_cmp++;
        if (cap_n !== 4) begin
            n_bad++; $display("FAIL busy_count: got %0d retires want 4", cap_n);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cap_rd[k] !== erd[k] || cap_dat[k] !== edat[k]) begin
                n_bad++;
                $display("FAIL busy_slot%0d: got rd=%0d data=%h want rd=%0d data=%h", k, cap_rd[k], cap_dat[k], erd[k], edat[k]);
            end
        end
        n_cmp++;
        if (cap_id[3] !== 7'h03) begin
            n_bad++; $display("FAIL busy_id: got %h want 03", cap_id[3]);
        end
        // add x21,x20,x0: x20 must still be 0 since the intruding block was dropped.
        cap_clear();
        offer(B_READBACK, 7'h05);
        capture(8);
        block_valid_in = 1'b0;
        n_cmp++;
        if (cap_n !== 4 || cap_rd[0] !== 5'd21 || cap_dat[0] !== 32'd0) begin
            n_bad++; $display("FAIL busy_readback: got n=%0d rd=%0d data=%h want n=4 rd=21 data=0", cap_n, cap_rd[0], cap_dat[0]);
        end
    endtask

    task automatic test_signed_x0_illegal();
        logic [4:0]  erd [4];
        logic [31:0] edat [4];
        logic        eill [4];
        erd = '{5'd1, 5'd2, 5'd0, 5'd0};
        edat = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
        eill = '{1'b0, 1'b0, 1'b0, 1'b1};
        cap_clear();
        offer(B_SIGNED, 7'h7F);
        capture(8);
        block_valid_in = 1'b0;
        n_cmp++;
        if (cap_n !== 4) begin
            n_bad++; $display("FAIL signed_count: got %0d retires want 4", cap_n);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cap_rd[k] !== erd[k] || cap_dat[k] !== edat[k] || cap_ill[k] !== eill[k]) begin
                n_bad++;
                $display("FAIL signed_slot%0d: got rd=%0d data=%h ill=%b want rd=%0d data=%h ill=%b",
                         k, cap_rd[k], cap_dat[k], cap_ill[k], erd[k], edat[k], eill[k]);
            end
        end
        n_cmp++;
        if (cap_id[3] !== 7'h7F) begin
            n_bad++; $display("FAIL signed_id: got %h want 7f", cap_id[3]);
        end
    endtask

    task automatic test_alu();
        logic [4:0]  erd [4];
        logic [31:0] edat [4];
        // lui x8,0x80000; srai x9,x8,4; sub x12,x0,x1 (x1=-1); slt x13,x1,x0
        erd = '{5'd8, 5'd9, 5'd12, 5'd13};
        edat = '{32'h80000000, 32'hF8000000, 32'd1, 32'd1};
        cap_clear();
        offer(B_ALU, 7'h2A);
        capture(8);
        block_valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cap_rd[k] !== erd[k] || cap_dat[k] !== edat[k] || cap_ill[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL alu_slot%0d: got rd=%0d data=%h ill=%b want rd=%0d data=%h ill=0",
                         k, cap_rd[k], cap_dat[k], cap_ill[k], erd[k], edat[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  lat;
        bit  seen;
        offer(B1, 7'h06);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (block_done === 1'b1) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL b2b_done_timeout: got no block_done in 10 cycles want one");
        end
        // Valid stays high; new data becomes acceptable the cycle after block_done.
        block_data_in = B2;
        lat = 0;
        seen = 0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(negedge clk);
            if (retire_valid === 1'b1) begin
                seen = 1; lat = i;
                n_cmp++;
                if (retire_rd !== 5'd4 || retire_data !== 32'd4) begin
                    n_bad++; $display("FAIL b2b_first: got rd=%0d data=%h want rd=4 data=4", retire_rd, retire_data);
                end
            end
        end
        n_cmp++;
        if (lat !== 2) begin
            n_bad++; $display("FAIL b2b_latency: got %0d cycles want 2", lat);
        end
        capture(6);
        block_valid_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [4:0]  erd [4];
        logic [31:0] edat [4];
        erd = '{5'd10, 5'd5, 5'd11, 5'd6};
        edat = '{32'd5, 32'd5, 32'd6, 32'd11};
        cap_clear();
        offer(B2, 7'h09);
        capture(2);
        n_cmp++;
        if (cap_n !== 1) begin
            n_bad++; $display("FAIL rstmid_pre: got %0d retires want 1", cap_n);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, retire_valid, retire_rd, retire_data, retire_illegal, block_done, block_id_out} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got busy=%b rv=%b rd=%0d data=%h ill=%b done=%b id=%h, want all 0",
                     busy, retire_valid, retire_rd, retire_data, retire_illegal, block_done, block_id_out);
        end
        block_valid_in = 1'b0;
        @(negedge clk); rst = 1'b1;
        // x4 was cleared by reset, so slot1 sees 0 and yields 5.
        cap_clear();
        offer(B1, 7'h01);
        capture(8);
        block_valid_in = 1'b0;
        n_cmp++;
        if (cap_n !== 4) begin
            n_bad++; $display("FAIL rstmid_count: got %0d retires want 4", cap_n);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cap_rd[k] !== erd[k] || cap_dat[k] !== edat[k]) begin
                n_bad++;
                $display("FAIL rstmid_slot%0d: got rd=%0d data=%h want rd=%0d data=%h", k, cap_rd[k], cap_dat[k], erd[k], edat[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_change();
        test_busy_offer();
        test_signed_x0_illegal();
        test_alu();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
